pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the fetch stage. It holds the architectural PC and selects the next PC from these sources: sequential increment, branch, jump, call/return (via an internal return-address stack) and trap vector. Priority between sources is fixed. It drives fetch with a valid/ready handshake and inserts a one-cycle bubble after every redirect. It sits between the branch/exception logic of the datapath and the instruction-memory port.

Parameters:
WIDTH, 32, PC and target width in bits
RESET_VECTOR, 0, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap
INSTR_BYTES, 4, sequential increment; power of two, >=1
RAS_DEPTH, 4, return-address-stack entries; power of two, >=2

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
stall  in  1  hold PC; ignored when a redirect is asserted
trap  in  1  redirect to TRAP_VECTOR
branch_taken  in  1  redirect to branch_target
branch_target  in  WIDTH  branch destination
jump  in  1  redirect to jump_target
call  in  1  qualifies jump: push return address
ret  in  1  redirect to the RAS top, with pop
jump_target  in  WIDTH  jump destination; fallback for ret on empty RAS
fetch_ready  in  1  instruction memory accepts pc_out
pc_out  out  WIDTH  current fetch PC
fetch_valid  out  1  pc_out is a valid fetch request
redirect  out  1  registered; high for the cycle after a redirect is taken
ras_overflow  out  1  sticky; a push overwrote a live entry
ras_underflow  out  1  sticky; ret was taken with the RAS empty

Behaviour:
- Reset (reset_n low, asynchronous): pc_out=RESET_VECTOR, fetch_valid=0, redirect=0, RAS count=0, RAS pointer=0, both sticky flags=0. Flags clear only on reset.
- First rising edge after reset_n releases: fetch_valid becomes 1 and pc_out is unchanged.
- Alignment: all targets have their low log2(INSTR_BYTES) bits forced to 0 before they are loaded.
- Fixed priority each cycle, highest first: trap > branch_taken > ret > jump > sequential.
- Redirect sources (trap, branch_taken, ret, jump) act regardless of stall and fetch_ready.
- On a redirect: pc_out <= target on the next edge. On that same edge fetch_valid <= 0 and redirect <= 1. On the following edge fetch_valid returns to 1 and redirect returns to 0, unless another redirect arrives.
- Sequential advance: pc_out <= pc_out + INSTR_BYTES only when fetch_valid & fetch_ready & ~stall. The sum wraps modulo 2^WIDTH (for example, all-ones-minus-3 goes to 0). Otherwise pc_out holds.
- Handshake: while fetch_valid=1 and fetch_ready=0, pc_out stays stable unless a redirect occurs. A redirect may abandon an unaccepted request.
- Return-address stack (RAS), effective only when the jump or ret actually wins priority:
  - Push (jump & call): writes pc_out + INSTR_BYTES, wrapped. Count saturates at RAS_DEPTH. A push when full overwrites the oldest entry (circular) and sets ras_overflow.
  - Pop (ret): target = top entry; count decrements.
  - ret with count=0: target = jump_target, ras_underflow=1, count stays 0.
  - ret & call together: pop then push in the same edge (replace top); count unchanged; return address pushed = pc_out + INSTR_BYTES.
  - When trap or branch_taken wins, call and ret have no RAS effect.
- A trap also flushes the RAS: count <= 0 on the same edge. Sticky flags are unaffected.
- reset_n asserted mid-operation: immediate return to the reset state; any in-flight request is dropped.

Decomposition:
- Package pc_pkg: redirect-source enum (SRC_SEQ, SRC_JUMP, SRC_RET, SRC_BRANCH, SRC_TRAP) and a function align(target, INSTR_BYTES).
- Sub-module pc_ras (parameters WIDTH, RAS_DEPTH): ports push, pop, push_data, top, empty, full, overflow_evt. It is instantiated once.
- The top level holds the priority mux, PC register, handshake and flags.

Test Plan:
- Reset release, fetch_ready=1, no redirects -> cycle 1 pc_out=0 with fetch_valid=1; then 4, 8, 12; fetch_ready=0 for 2 cycles holds 12.
- At pc_out=0x20, branch_taken=1 and trap=1 with branch_target=0x80 -> pc_out=0x100, fetch_valid=0 and redirect=1 for one cycle, RAS count=0.
- jump & call at pc_out=0x40 to 0x200, then ret at 0x208 -> pc_out=0x44, ras_underflow=0.
- RAS_DEPTH=4: five nested calls from 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_overflow=1; five rets return 0x54, 0x44, 0x34, 0x24, then the fifth ret yields jump_target (0x300) and sets ras_underflow=1.
- WIDTH=16: pc_out=0xFFFC, advance -> 0x0000. jump_target=0x1237 -> pc_out=0x1234.
- stall=1 with jump=1 to 0x400 -> redirect taken to 0x400. Assert reset_n=0 mid-stall -> pc_out=RESET_VECTOR immediately and all flags cleared.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the fetch-stage program counter.
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_JUMP,
        SRC_RET,
        SRC_BRANCH,
        SRC_TRAP
    } pc_src_e;

    function automatic logic [63:0] align(input logic [63:0] target, input int instr_bytes);
        return target & ~(64'(instr_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow_evt
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    ptr, prev;
    logic [PW:0]      count;
    logic             do_pop;

    assign prev         = ptr - PW'(1);
    assign empty        = count == '0;
    assign full         = count == (PW+1)'(RAS_DEPTH);
    assign do_pop       = pop & ~empty;
    assign top          = mem[prev];
    assign overflow_evt = push & full & ~do_pop;

    // pop+push together rewrites the current top in place
    always_ff @(posedge clk)
        if (push && !flush)
            mem[do_pop ? prev : ptr] <= push_data;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            ptr   <= (push && do_pop) ? ptr : push ? ptr + PW'(1) : do_pop ? prev : ptr;
            count <= (push && do_pop) ? count
                   : push ? (full ? count : count + (PW+1)'(1))
                   : do_pop ? count - (PW+1)'(1) : count;
        end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with prioritised redirects and a return-address stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
    parameter int               INSTR_BYTES  = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             trap,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             fetch_ready,
    output logic [WIDTH-1:0] pc_out,
    output logic             fetch_valid,
    output logic             redirect,
    output logic             ras_overflow,
    output logic             ras_underflow
);
    pc_src_e          src;
    logic [WIDTH-1:0] seq_pc, raw_target, target, ras_top;
    logic             take, push, pop, flush, ras_empty, ras_full, ovf_evt;

    always_comb begin
        src = trap ? SRC_TRAP : branch_taken ? SRC_BRANCH : ret ? SRC_RET : jump ? SRC_JUMP : SRC_SEQ;
        raw_target = src == SRC_TRAP ? TRAP_VECTOR
                   : src == SRC_BRANCH ? branch_target
                   : (src == SRC_RET && !ras_empty) ? ras_top
                   : jump_target;
    end

    assign target = WIDTH'(align(64'(raw_target), INSTR_BYTES));
    assign seq_pc = pc_out + WIDTH'(INSTR_BYTES);
    assign take   = src != SRC_SEQ;
    assign pop    = src == SRC_RET;
    assign push   = call && (src == SRC_JUMP || src == SRC_RET);
    assign flush  = src == SRC_TRAP;

    pc_ras #(
        .WIDTH(WIDTH),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk(clk),
        .reset_n(reset_n),
        .flush(flush),
        .push(push),
        .pop(pop),
        .push_data(seq_pc),
        .top(ras_top),
        .empty(ras_empty),
        .full(ras_full),
        .overflow_evt(ovf_evt)
    );

    // a redirect always costs one bubble: fetch_valid drops on the edge that loads the target
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pc_out        <= RESET_VECTOR;
            fetch_valid   <= 1'b0;
            redirect      <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc_out        <= take ? target : (fetch_valid && fetch_ready && !stall) ? seq_pc : pc_out;
            fetch_valid   <= !take;
            redirect      <= take;
            ras_overflow  <= ras_overflow | (ovf_evt & ras_full);
            ras_underflow <= ras_underflow | (pop & ras_empty);
        end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n, stall, trap, branch_taken, jump, call, ret, fetch_ready;
    logic [31:0] branch_target, jump_target, pc_out;
    logic        fetch_valid, redirect, ras_overflow, ras_underflow;
    int          checks = 0, failures = 0;

    logic [31:0] m_pc;
    logic        m_fv, m_rd, m_ovf, m_unf;
    logic [31:0] stk[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .WIDTH(32),
        .RESET_VECTOR(32'h0),
        .TRAP_VECTOR(TV),
        .INSTR_BYTES(4),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .stall(stall),
        .trap(trap),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .call(call),
        .ret(ret),
        .jump_target(jump_target),
        .fetch_ready(fetch_ready),
        .pc_out(pc_out),
        .fetch_valid(fetch_valid),
        .redirect(redirect),
        .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"}, pc_out, m_pc);
        chk({tag, ".valid"}, 32'(fetch_valid), 32'(m_fv));
        chk({tag, ".redirect"}, 32'(redirect), 32'(m_rd));
        chk({tag, ".ovf"}, 32'(ras_overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
    endtask

    task automatic m_reset();
        m_pc = 32'h0; m_fv = 1'b0; m_rd = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        stk.delete();
    endtask

    task automatic m_push(input logic [31:0] v);
        stk.push_back(v);
        if (stk.size() > 4) begin
            stk.delete(0);
            m_ovf = 1'b1;
        end
    endtask

    // next-state rules: priority trap > branch > ret > jump > sequential
    task automatic m_step();
        logic [31:0] nxt;
        logic        redir;
        logic [31:0] ra;
        redir = 1'b1;
        ra = m_pc + 32'd4;
        if (trap) begin
            nxt = TV;
            stk.delete();
        end else if (branch_taken) begin
            nxt = branch_target & ~32'h3;
        end else if (ret) begin
            if (stk.size() == 0) begin
                nxt = jump_target & ~32'h3;
                m_unf = 1'b1;
            end else begin
                nxt = stk.pop_back();
            end
            if (call) m_push(ra);
        end else if (jump) begin
            nxt = jump_target & ~32'h3;
            if (call) m_push(ra);
        end else begin
            redir = 1'b0;
            nxt = (m_fv && fetch_ready && !stall) ? ra : m_pc;
        end
        m_pc = nxt; m_fv = !redir; m_rd = redir;
    endtask

    task automatic cyc(input string tag);
        m_step();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic quiet();
        trap = 1'b0; branch_taken = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic go_to(input logic [31:0] a);
        quiet(); jump = 1'b1; jump_target = a;
        cyc("goto");
        quiet();
        cyc("goto_idle");
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 m_reset();
        chk_all(tag);
        chk({tag, ".pc_now"}, pc_out, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
        branch_target = '0; jump_target = '0;
        quiet();
        m_reset();
        repeat (2) @(posedge clk);
        #1 chk_all("reset");
        reset_n = 1'b1;

        cyc("first");
        chk("first_pc", pc_out, 32'h0);
        chk("first_valid", 32'(fetch_valid), 32'd1);
        cyc("seq"); chk("seq4", pc_out, 32'h4);
        cyc("seq"); chk("seq8", pc_out, 32'h8);
        cyc("seq"); chk("seq12", pc_out, 32'hC);
        fetch_ready = 1'b0;
        repeat (2) cyc("hold");
        chk("hold12", pc_out, 32'hC);
        fetch_ready = 1'b1;
        repeat (5) cyc("adv");
        chk("at20", pc_out, 32'h20);

        trap = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        cyc("trap");
        chk("trap_pc", pc_out, 32'h100);
        chk("trap_valid", 32'(fetch_valid), 32'd0);
        chk("trap_redir", 32'(redirect), 32'd1);
        quiet();
        cyc("trap_after");
        chk("trap_after_redir", 32'(redirect), 32'd0);

        go_to(32'h40);
        jump = 1'b1; call = 1'b1; jump_target = 32'h200;
        cyc("call");
        chk("call_pc", pc_out, 32'h200);
        quiet();
        repeat (3) cyc("callee");
        chk("at208", pc_out, 32'h208);
        ret = 1'b1; jump_target = 32'h300;
        cyc("ret");
        chk("ret_pc", pc_out, 32'h44);
        chk("ret_unf", 32'(ras_underflow), 32'd0);
        quiet();

        go_to(32'h40);
        jump = 1'b1; call = 1'b1; jump_target = 32'h200;
        cyc("call2");
        quiet(); trap = 1'b1;
        cyc("flush_trap");
        quiet(); ret = 1'b1; jump_target = 32'h300;
        cyc("ret_flushed");
        chk("flush_pc", pc_out, 32'h300);
        chk("flush_unf", 32'(ras_underflow), 32'd1);
        quiet();
        pulse_reset("rst1");

        go_to(32'h10);
        for (int k = 2; k <= 6; k++) begin
            jump = 1'b1; call = 1'b1; jump_target = 32'(k * 16);
            cyc("nest");
        end
        chk("nest_ovf", 32'(ras_overflow), 32'd1);
        quiet(); ret = 1'b1; jump_target = 32'h300;
        cyc("r1"); chk("r1_pc", pc_out, 32'h54);
        cyc("r2"); chk("r2_pc", pc_out, 32'h44);
        cyc("r3"); chk("r3_pc", pc_out, 32'h34);
        cyc("r4"); chk("r4_pc", pc_out, 32'h24);
        chk("r4_unf", 32'(ras_underflow), 32'd0);
        cyc("r5"); chk("r5_pc", pc_out, 32'h300);
        chk("r5_unf", 32'(ras_underflow), 32'd1);
        quiet();

        go_to(32'hFFFF_FFFC);
        cyc("wrap");
        chk("wrap_pc", pc_out, 32'h0);
        jump = 1'b1; jump_target = 32'h1237;
        cyc("align_j");
        chk("align_j_pc", pc_out, 32'h1234);
        quiet(); branch_taken = 1'b1; branch_target = 32'h57;
        cyc("align_b");
        chk("align_b_pc", pc_out, 32'h54);
        quiet();

        stall = 1'b1; jump = 1'b1; jump_target = 32'h400;
        cyc("stall_jump");
        chk("stall_jump_pc", pc_out, 32'h400);
        quiet();
        repeat (2) cyc("stalled");
        chk("stalled_pc", pc_out, 32'h400);
        pulse_reset("rst_stall");
        chk("rst_ovf", 32'(ras_overflow), 32'd0);
        chk("rst_unf", 32'(ras_underflow), 32'd0);
        stall = 1'b0;

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                quiet();
                pulse_reset("rnd_rst");
            end
            trap          = ($urandom_range(0, 15) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            ret           = ($urandom_range(0, 5) == 0);
            jump          = ($urandom_range(0, 4) == 0);
            call          = ($urandom_range(0, 1) == 1);
            stall         = ($urandom_range(0, 3) == 0);
            fetch_ready   = ($urandom_range(0, 3) != 0);
            branch_target = $urandom;
            jump_target   = $urandom;
            cyc("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
